// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus iterative unsigned
// shift-add multiply and restoring divide into hi/lo, with a debug state output.
module mc_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [3:0]       alucontrol,
  output logic [WIDTH-1:0] aluout,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;
  localparam logic [3:0] OP_MFHI  = 4'b1010;
  localparam logic [3:0] OP_MFLO  = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     op_a, op_b;
  logic [2*WIDTH-1:0]   acc, acc_nxt;
  logic [WIDTH-1:0]     single_res;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH+1:0]     div_diff;
  logic                 accept;
  logic                 last_step;

  // Handshake: start is consumed only on a rising edge where state is IDLE;
  // otherwise it is dropped with no side effects.
  assign accept    = start && (state_q == IDLE);
  assign zero      = (aluout == '0);
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    last_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && alucontrol == OP_MULTU)
          state_d = MUL;
        else if (accept && alucontrol == OP_DIVU && srcb != '0)
          state_d = DIV;
      end
      MUL, DIV: begin
        if (cnt == CW'(1)) begin
          last_step = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    single_res = srca + srcb;
    case (alucontrol)
      OP_AND:  single_res = srca & srcb;
      OP_OR:   single_res = srca | srcb;
      OP_SUB:  single_res = srca - srcb;
      OP_SLT:  single_res = WIDTH'($signed(srca) < $signed(srcb));
      OP_SLTU: single_res = WIDTH'(srca < srcb);
      OP_MFHI: single_res = hi;
      OP_MFLO: single_res = lo;
      default: single_res = srca + srcb;
    endcase
  end

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op_a} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, op_b};
    acc_nxt   = acc;
    if (state_q == MUL) begin
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end else if (state_q == DIV) begin
      if (!div_diff[WIDTH+1])
        acc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_nxt = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aluout  <= '0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      divzero <= 1'b0;
      cnt     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      acc     <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        case (alucontrol)
          OP_MULTU: begin
            op_a <= srca;
            op_b <= srcb;
            acc  <= {{WIDTH{1'b0}}, srcb};
            cnt  <= CW'(WIDTH);
            busy <= 1'b1;
          end
          OP_DIVU: begin
            op_a <= srca;
            op_b <= srcb;
            if (srcb == '0) begin
              lo      <= '1;
              hi      <= srca;
              aluout  <= '1;
              divzero <= 1'b1;
              done    <= 1'b1;
            end else begin
              acc  <= {{WIDTH{1'b0}}, srca};
              cnt  <= CW'(WIDTH);
              busy <= 1'b1;
            end
          end
          default: begin
            aluout <= single_res;
            done   <= 1'b1;
          end
        endcase
      end else if (state_q != IDLE) begin
        acc <= acc_nxt;
        cnt <= cnt - CW'(1);
        if (last_step) begin
          hi     <= acc_nxt[2*WIDTH-1:WIDTH];
          lo     <= acc_nxt[WIDTH-1:0];
          aluout <= acc_nxt[WIDTH-1:0];
          busy   <= 1'b0;
          done   <= 1'b1;
          if (state_q == DIV) divzero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mc_alu.sv
// Directed bench for mc_alu (WIDTH=32): single-cycle ops, multiply/divide
// timing, divide-by-zero, busy protection, async reset and back-to-back ops.
module tb_mc_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] srca, srcb;
  logic [3:0]   alucontrol;
  logic [W-1:0] aluout, hi, lo;
  logic         zero, busy, done, divzero;
  logic [1:0]   dbg_state;

  int errors = 0;
  int checks = 0;
  int n;
  int done_seen;

  mc_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .srca       (srca),
    .srcb       (srcb),
    .alucontrol (alucontrol),
    .aluout     (aluout),
    .zero       (zero),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .divzero    (divzero),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    start      = 1'b1;
    alucontrol = op;
    srca       = a;
    srcb       = b;
    step();
    start = 1'b0;
  endtask

  // Counts sampled cycles with busy high, bounded so a stuck busy cannot hang the run.
  task automatic wait_busy(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      step();
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    srca       = '0;
    srcb       = '0;
    alucontrol = 4'b0000;
    repeat (2) @(negedge clk);
    check("rst_aluout", aluout, 0);
    check("rst_zero", zero, 1);
    check("rst_hilo", {hi, lo}, 0);
    check("rst_flags", {busy, done, divzero}, 0);
    check("rst_state", dbg_state, 0);
    reset_n = 1'b1;

    // add on the first edge after release
    issue(4'b0010, 5, 7);
    check("add_out", aluout, 12);
    check("add_zero", zero, 0);
    check("add_done", done, 1);
    check("add_busy", busy, 0);
    step();
    check("add_done_one_cycle", done, 0);
    check("add_hold", aluout, 12);

    issue(4'b0110, 7, 7);
    check("sub_out", aluout, 0);
    check("sub_zero", zero, 1);
    issue(4'b0110, 3, 5);
    check("sub_wrap", aluout, 32'hFFFF_FFFE);
    issue(4'b0111, 32'hFFFF_FFFF, 1);
    check("slt_out", aluout, 1);
    issue(4'b0011, 32'hFFFF_FFFF, 1);
    check("sltu_out", aluout, 0);
    issue(4'b0000, 32'h0000_F0F0, 32'h0000_FF00);
    check("and_out", aluout, 32'h0000_F000);
    issue(4'b0001, 32'h0000_F0F0, 32'h0000_FF00);
    check("or_out", aluout, 32'h0000_FFF0);
    issue(4'b1111, 3, 4);
    check("unknown_is_add", aluout, 7);
    check("state_idle_single", dbg_state, 0);

    // multu with operand scrambling after E0 and an ignored start at cycle 5
    issue(4'b1000, 32'hFFFF_FFFF, 2);
    srca = 32'h1234_5678;
    srcb = 32'h0;
    check("mul_busy_e0", busy, 1);
    check("mul_state", dbg_state, 1);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      start      = (n == 5);
      alucontrol = 4'b0010;
      if (n == 16) begin
        check("mul_hold_aluout", aluout, 7);
        check("mul_hold_hilo", {hi, lo}, 0);
        check("mul_no_done", done, 0);
      end
      step();
    end
    start = 1'b0;
    check("mul_latency", n, 32);
    check("mul_done", done, 1);
    check("mul_hi", hi, 32'h0000_0001);
    check("mul_lo", lo, 32'hFFFF_FFFE);
    check("mul_aluout", aluout, 32'hFFFF_FFFE);
    check("mul_state_back", dbg_state, 0);
    step();
    check("mul_ignored_start", {done, busy}, 0);
    check("mul_ignored_aluout", aluout, 32'hFFFF_FFFE);

    issue(4'b1010, 0, 0);
    check("mfhi_out", aluout, 1);
    check("mfhi_hi_kept", hi, 1);
    issue(4'b1011, 0, 0);
    check("mflo_out", aluout, 32'hFFFF_FFFE);

    // divide by zero completes at E0 with no busy phase
    issue(4'b1001, 32'h1234, 0);
    check("dz_done", done, 1);
    check("dz_busy", busy, 0);
    check("dz_state", dbg_state, 0);
    check("dz_lo", lo, 32'hFFFF_FFFF);
    check("dz_hi", hi, 32'h1234);
    check("dz_aluout", aluout, 32'hFFFF_FFFF);
    check("dz_flag", divzero, 1);
    issue(4'b0010, 1, 1);
    check("dz_flag_holds", divzero, 1);

    // divu 100/7, then multu issued in its done cycle
    issue(4'b1001, 100, 7);
    check("div_state", dbg_state, 2);
    wait_busy(n);
    check("div_latency", n, 32);
    check("div_done", done, 1);
    check("div_lo", lo, 14);
    check("div_hi", hi, 2);
    check("div_aluout", aluout, 14);
    check("div_flag_clear", divzero, 0);
    issue(4'b1000, 32'h0001_0003, 32'h0000_0005);
    check("b2b_busy", busy, 1);
    wait_busy(n);
    check("b2b_latency", n, 32);
    check("b2b_done", done, 1);
    check("b2b_lo", lo, 32'h0005_000F);
    check("b2b_hi", hi, 0);

    // divide with remainder wide enough to exercise the top bits
    issue(4'b1001, 32'hFFFF_FFFF, 32'h0001_0000);
    wait_busy(n);
    check("div2_lo", lo, 32'h0000_FFFF);
    check("div2_hi", hi, 32'h0000_FFFF);

    // async reset during cycle 10 of a multiply
    issue(4'b1000, 9, 9);
    repeat (9) step();
    check("rst_mid_busy_before", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_hilo", {hi, lo}, 0);
    check("rst_mid_aluout", aluout, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_zero", zero, 1);
    check("rst_mid_state", dbg_state, 0);
    @(negedge clk);
    reset_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    check("rst_mid_no_done", done_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_alu.md
MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand, result, hi and lo width; legal values are 8 to 64, and the value must be even.
REQ-002 Port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 Port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 Port start, input, 1 bit: requests an operation, sampled at the rising clk edge.
REQ-005 Port srca, input, WIDTH bits: operand A.
REQ-006 Port srcb, input, WIDTH bits: operand B.
REQ-007 Port alucontrol, input, 4 bits: opcode; see REQ-012.
REQ-008 Port aluout, output, WIDTH bits: registered result.
REQ-009 Port zero, output, 1 bit: high exactly when aluout equals 0 (combinational from aluout).
REQ-010 Ports hi and lo, outputs, WIDTH bits each: registered multiply/divide result.
REQ-011 Ports busy, done and divzero, outputs, 1 bit each:
- busy: an iterative operation is in progress.
- done: one-cycle completion pulse.
- divzero: the last divide had srcb equal to 0.

Function
REQ-012 Opcode map:
- 0010 add, 0110 sub, 0000 and, 0001 or.
- 0111 slt (signed), 0011 sltu (unsigned).
- 1010 mfhi, 1011 mflo.
- 1000 multu, 1001 divu.
- Any other code is treated as add.
REQ-013 States: IDLE, MUL, DIV; the block leaves reset in IDLE.
REQ-014 start is accepted only in IDLE; start while busy=1 is ignored and has no side effects.
REQ-015 Single-cycle ops (add, sub, and, or, slt, sltu, mfhi, mflo):
- On the accepting edge E0, aluout is loaded and done=1 for exactly one cycle.
- The state remains IDLE.
REQ-016 add and sub wrap modulo 2^WIDTH; no overflow flag is produced.
REQ-017 slt and sltu write 1 to aluout when srca < srcb (signed or unsigned respectively), else 0.
REQ-018 mfhi and mflo copy hi or lo into aluout; hi and lo are unchanged.
REQ-019 Operand latching: multu and divu latch srca and srcb at E0. Input changes after E0 do not affect the result.
REQ-020 multu uses unsigned shift-add, one bit per cycle:
- At E0, busy=1 and the state becomes MUL.
- Steps occur at edges E1 through E_WIDTH.
- At E_WIDTH, {hi,lo} is loaded with the 2*WIDTH-bit product, aluout is loaded with the product's low half, busy=0, done=1 for one cycle, and the state returns to IDLE.
REQ-021 divu uses unsigned restoring division with the same timing as multu (state DIV):
- lo = quotient, hi = remainder.
- aluout = quotient.
- divzero=0.
REQ-022 divu with srcb=0 completes at E0 with no busy phase:
- lo = all ones, hi = srca, aluout = all ones.
- divzero=1, done=1.
REQ-023 divzero holds its value until the next divu completes or reset occurs.
REQ-024 While busy=1, aluout, hi and lo hold their previous values; they update only at completion.
REQ-025 A new start is accepted in the same cycle done is high, provided the state is IDLE, so back-to-back operations are legal.
REQ-026 The iteration counter is log2(WIDTH)+1 bits wide; it is loaded at E0 and counts down to terminal count with no wrap-around.

Reset
REQ-027 When reset_n=0, the block SHALL immediately and asynchronously:
- set state to IDLE;
- clear aluout, hi, lo, busy, done, divzero, the counter and the latched operands to 0.
REQ-028 Reset mid-operation abandons the operation; no done pulse is issued for it.
REQ-029 After reset, zero=1 because aluout=0.
REQ-030 The first start is accepted on the first rising edge after reset_n returns high.

Verification (WIDTH=32)
REQ-031 Single-cycle arithmetic and flags:
- add 5+7 → aluout=12, zero=0, done=1 for exactly one cycle after E0.
- sub 7-7 → aluout=0, zero=1.
REQ-032 Signed versus unsigned compare:
- slt with srca=0xFFFFFFFF, srcb=1 → aluout=1.
- sltu with the same operands → aluout=0.
REQ-033 Multiply timing and busy protection:
- multu 0xFFFFFFFF × 2 → busy high for exactly 32 cycles, then hi=0x00000001, lo=0xFFFFFFFE, done pulse.
- A start with add asserted at cycle 5 of the multiply is ignored.
- A following mfhi → aluout=1.
REQ-034 Divide and divide-by-zero:
- divu 100/7 → lo=14, hi=2, divzero=0, latency 32 cycles.
- divu 0x1234/0 → lo=0xFFFFFFFF, hi=0x1234, divzero=1, done at E0, busy never high.
REQ-035 Reset mid-operation: reset_n=0 during cycle 10 of a multu → busy=0, hi=lo=aluout=0, done=0 without waiting for a clock edge; no done pulse follows after release.
REQ-036 Back-to-back operations: multu issued in the done cycle of a previous divu → accepted, completes 32 cycles later.
